interface_port_master: RTL

//  Upstream bus master for interface_port_io. Generates the time-multiplexed 8-bit slot

---
 rtl/interface_port_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/interface_port_master.sv
// interface_port_master: drives the DIR/WRITE/READ slot schedule on the shared data bus; optional input-change irq under PORT_IN_CHANGE_IRQ_EN.
// Latency: bus drive is registered one slot ahead of use; host read data returns 1 cycle after host_rd.
// Backpressure: none; one slot per clock and every host access is accepted immediately.
module interface_port_master #(
  parameter int NUM_PORTS = 3
) (
  input  logic       port_clk,
  input  logic       port_rst,
  inout  wire  [7:0] data,
  input  logic [5:0] host_addr,
  input  logic       host_wr,
  input  logic [7:0] host_wdata,
  input  logic       host_rd,
  output logic [7:0] host_rdata,
  output logic       host_rvalid,
  output logic       frame_done,
  output logic       irq
);

  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_DIR   = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_LAST  = 3'd4;

  localparam logic [4:0] LAST_SLOT = 5'(3 * NUM_PORTS + 1);

  logic [2:0] state_q, state_nxt;
  logic [4:0] slot_q, slot_nxt;
  logic [3:0] port_q, port_nxt;
  logic       drv_en_q, drv_en_nxt;
  logic [7:0] drv_dat_q, drv_dat_nxt;

  logic [7:0] dir_sh  [NUM_PORTS];
  logic [7:0] out_sh  [NUM_PORTS];
  logic [7:0] dir_act [NUM_PORTS];
  logic [7:0] out_act [NUM_PORTS];
  logic [7:0] in_r    [NUM_PORTS];

`ifdef PORT_IN_CHANGE_IRQ_EN
  logic [7:0] chg_r  [NUM_PORTS];
  logic [7:0] mask_r [NUM_PORTS];
  logic       irq_q;
  logic       irq_any;
`endif

  logic [3:0] h_port;
  logic [1:0] h_sel;
  logic [7:0] rd_mux;

  assign h_port = host_addr[5:2];
  assign h_sel  = host_addr[1:0];

  // Registered enable keeps the bus free of glitches at slot boundaries.
  assign data = drv_en_q ? drv_dat_q : 8'hzz;

  always_comb begin
    state_nxt = ST_SYNC;
    slot_nxt  = 5'd0;
    port_nxt  = 4'd0;
    case (state_q)
      ST_SYNC: begin
        state_nxt = ST_DIR;
        slot_nxt  = 5'd1;
      end
      ST_DIR: begin
        state_nxt = ST_WRITE;
        slot_nxt  = slot_q + 5'd1;
        port_nxt  = port_q;
      end
      ST_WRITE: begin
        state_nxt = ST_READ;
        slot_nxt  = slot_q + 5'd1;
        port_nxt  = port_q;
      end
      ST_READ: begin
        if (slot_q == LAST_SLOT - 5'd1) begin
          state_nxt = ST_LAST;
          slot_nxt  = LAST_SLOT;
        end else begin
          state_nxt = ST_DIR;
          slot_nxt  = slot_q + 5'd1;
          port_nxt  = port_q + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_SYNC;
      end
    endcase
  end

  always_comb begin
    drv_en_nxt  = (state_nxt == ST_DIR) || (state_nxt == ST_WRITE);
    drv_dat_nxt = 8'h00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_nxt == 4'(p)) begin
        drv_dat_nxt = (state_nxt == ST_DIR) ? dir_act[p] : out_act[p];
      end
    end
  end

  // Out-of-range ports match no loop index, so they read as zero.
  always_comb begin
    rd_mux = 8'h00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (h_port == 4'(p)) begin
        case (h_sel)
          2'd0: rd_mux = dir_sh[p];
          2'd1: rd_mux = out_sh[p];
          2'd2: rd_mux = in_r[p];
`ifdef PORT_IN_CHANGE_IRQ_EN
          2'd3: rd_mux = mask_r[p];
`endif
          default: rd_mux = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge port_clk) begin
    if (port_rst) begin
      state_q     <= ST_SYNC;
      slot_q      <= 5'd0;
      port_q      <= 4'd0;
      drv_en_q    <= 1'b0;
      drv_dat_q   <= 8'h00;
      host_rdata  <= 8'h00;
      host_rvalid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      slot_q      <= slot_nxt;
      port_q      <= port_nxt;
      drv_en_q    <= drv_en_nxt;
      drv_dat_q   <= drv_dat_nxt;
      host_rvalid <= host_rd;
      frame_done  <= (state_nxt == ST_LAST);
      if (host_rd) begin
        host_rdata <= rd_mux;
      end
    end
  end

  // Commit samples the old shadow, so a write on the LAST edge lands a frame later.
  always_ff @(posedge port_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_rst) begin
        dir_sh[p]  <= 8'h00;
        out_sh[p]  <= 8'h00;
        dir_act[p] <= 8'h00;
        out_act[p] <= 8'h00;
        in_r[p]    <= 8'h00;
      end else begin
        if (host_wr && (h_port == 4'(p)) && (h_sel == 2'd0)) begin
          dir_sh[p] <= host_wdata;
        end
        if (host_wr && (h_port == 4'(p)) && (h_sel == 2'd1)) begin
          out_sh[p] <= host_wdata;
        end
        if (state_q == ST_LAST) begin
          dir_act[p] <= dir_sh[p];
          out_act[p] <= out_sh[p];
        end
        if ((state_q == ST_READ) && (port_q == 4'(p))) begin
          in_r[p] <= data;
        end
      end
    end
  end

`ifdef PORT_IN_CHANGE_IRQ_EN
  always_comb begin
    irq_any = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      irq_any = irq_any | (|(chg_r[p] & mask_r[p]));
    end
  end

  // A change captured on the same edge as an IN read survives the clear.
  always_ff @(posedge port_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_rst) begin
        chg_r[p]  <= 8'h00;
        mask_r[p] <= 8'h00;
      end else begin
        if (host_wr && (h_port == 4'(p)) && (h_sel == 2'd3)) begin
          mask_r[p] <= host_wdata;
        end
        chg_r[p] <= ((host_rd && (h_port == 4'(p)) && (h_sel == 2'd2)) ? 8'h00 : chg_r[p]) |
                    (((state_q == ST_READ) && (port_q == 4'(p))) ? (data ^ in_r[p]) : 8'h00);
      end
    end
    if (port_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_any;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
